// File: rtl/l_stf_seq.sv
// l_stf_seq: streams the 802.11 legacy short training field out of a
// 16-entry combinational-read STF ROM as NUM_REP x 16 samples on a
// valid/ready stream, then pulses done so the L-LTF stage can follow.
//
// Optional build macro STF_WINDOW_EN: halves the first sample of the burst
// and appends one extra half-amplitude copy of ROM entry 0 as the final
// sample (time-domain boundary window). Undefined: plain NUM_REP x 16 burst.
//
// Stream handshake: out_sample/out_last are valid while out_valid is high and
// are held unchanged until the cycle in which out_ready is also high; that
// cycle is the transfer. A new sample is loaded whenever the output register
// is empty or is being transferred (!out_valid | out_ready).
module l_stf_seq #(
    parameter int NUM_REP = 10,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        phy_tx_arestn,
    input  logic        start,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    localparam int BASE_LEN = NUM_REP * 16;
`ifdef STF_WINDOW_EN
    localparam int BURST_LEN = BASE_LEN + 1;
`else
    localparam int BURST_LEN = BASE_LEN;
`endif
    localparam logic [CNT_W-1:0] LEN_C      = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic [31:0]      shaped;
    logic             load;
    logic             take;

    // The ROM address is the low nibble of the sample index, so it wraps
    // 15 -> 0 at every STF period without extra logic.
    assign rom_addr    = cnt_q[3:0];
    assign out_sample  = sample_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;
    assign load        = !valid_q || out_ready;

    // Sample shaping: the window halves I and Q (arithmetic shift) on the
    // first sample and on the appended extra sample, which reads entry 0.
    always_comb begin
        shaped = rom_dout;
`ifdef STF_WINDOW_EN
        if (cnt_q == '0 || cnt_q == LAST_IDX_C) begin
            shaped = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
        end
`endif
    end

    // Next-state logic. The first sample is captured on the accepting start
    // edge itself (cnt is 0 in IDLE) so out_valid rises one cycle after start.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        take     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    take    = 1'b1;
                end
            end
            S_RUN: begin
                if (load) begin
                    if (cnt_q < LEN_C) begin
                        take = 1'b1;
                    end else begin
                        // Every sample loaded and the final one is leaving now.
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (take) begin
            sample_d = shaped;
            valid_d  = 1'b1;
            last_d   = (cnt_q == LAST_IDX_C);
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset asserts asynchronously so a mid-burst
    // reset drops the stream at once without a done pulse.
    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: doc/l_stf_seq.md
Name: l_stf_seq

Overview:
Sequencer that streams the 802.11 legacy short training field (L-STF) out of the 16-entry STF ROM. It drives the ROM address, registers the packed I/Q sample, and presents NUM_REP x 16 samples on a valid/ready stream toward the preamble mux / IFFT-output path. It starts on a single-cycle trigger from the TX controller and signals completion so the L-LTF stage can follow.

Parameters:
NUM_REP, 10, number of 16-sample STF periods emitted (10 -> 160 samples, 8 us at 20 MSps)
CNT_W, 8, width of internal sample counter; must satisfy 2^CNT_W > NUM_REP*16

Ports:
clk  in  1  system clock
phy_tx_arestn  in  1  asynchronous active-low reset
start  in  1  one-cycle trigger; begin STF burst
rom_addr  out  4  address to STF ROM (combinational-read ROM, 0..15)
rom_dout  in  32  ROM data, {I[15:0], Q[15:0]}, two's complement
out_sample  out  32  registered sample {I, Q}
out_valid  out  1  out_sample valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_last  out  1  high with final sample of burst
busy  out  1  high from accepted start until final sample accepted
done  out  1  one-cycle pulse the cycle after final sample accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, out_sample=0, out_valid=0, out_last=0, busy=0, done=0, rom_addr=0.
- rom_addr = cnt[3:0] combinationally; ROM read is same-cycle.
- FSM states IDLE, RUN, DONE.
- IDLE: start=1 -> RUN, cnt=0, busy=1. Other inputs ignored.
- RUN, load condition = (!out_valid | out_ready):
  - if cnt < NUM_REP*16: out_sample<=rom_dout, out_valid<=1, out_last<=(cnt==NUM_REP*16-1), cnt<=cnt+1.
  - if cnt == NUM_REP*16 (all loaded) and final sample accepted: out_valid<=0, out_last<=0 -> DONE.
- DONE: done=1 for exactly one cycle, busy<=0, -> IDLE.
- Throughput: with out_ready held 1, one sample per cycle; first out_valid appears 1 cycle after start; 160 consecutive valid cycles; done 1 cycle after last transfer.
- Backpressure: out_ready=0 while out_valid=1 -> out_sample, out_last, cnt, rom_addr hold; no sample dropped or duplicated.
- Address wraps 15->0 naturally each period; cnt never exceeds NUM_REP*16.
- start while busy or in DONE: ignored (no restart, no glitch).
- start in same cycle as done pulse: ignored; a new start is accepted only in IDLE.
- Reset mid-burst: all outputs return to reset values immediately; no done pulse.

Optional Feature:
STF_WINDOW_EN: when defined, first sample of burst (cnt==0) has I and Q each arithmetic-shifted right by 1 (half-amplitude boundary window per 802.11 time-domain windowing); also an extra final sample (equal to half-amplitude ROM entry 0) is appended, total NUM_REP*16+1, out_last on that extra sample. When undefined, samples pass unmodified and burst length is NUM_REP*16.

Test Plan:
- Reset, no start -> out_valid=0, busy=0, done=0 for 20 cycles; rom_addr=0.
- start pulse, out_ready=1 -> out_sample sequence 0x02F202F2, 0x02F2FD0E, 0xFD0EFD0E, 0xFD0E02F2, repeating; sample 16 = 0x02F202F2; 160 transfers; out_last only on 160th; done pulse 1 cycle later; busy low after.
- Random out_ready (50%) -> same 160-sample sequence, out_sample stable while stalled, no gaps/duplicates counted by scoreboard.
- start asserted again at sample 50 and in done cycle -> ignored; exactly 160 samples, one done pulse; start one cycle after done -> new 160-sample burst.
- phy_tx_arestn low at sample 80 -> out_valid/busy drop to 0 immediately, no done; subsequent start yields full 160 samples from 0x02F202F2.
- With STF_WINDOW_EN: first sample 0x01790179, samples 1..159 unmodified, 161st sample 0x01790179 with out_last=1.
